// File: rtl/flash_pkg.sv
// Shared encodings and default timing for the NOR flash access arbiter.
package flash_pkg;
  localparam int ADDR_W_DEF    = 22;
  localparam int DATA_W_DEF    = 16;
  localparam int WR_CYCLES_DEF = 24;
  localparam int RD_CYCLES_DEF = 16;
  localparam int CMD_HOLD_DEF  = 2;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam logic GNT_READ  = 1'b0;
  localparam logic GNT_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/flash_rr_arbiter.sv
// Two-way round-robin between log writer and readback; grant only while en_i.
module flash_rr_arbiter
  import flash_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic en_i,
  input  logic wr_req_i,
  input  logic rd_req_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);
  logic last_q;

  // On a tie the side that did not win last time goes first.
  assign gnt_wr_o = en_i && wr_req_i && (!rd_req_i || last_q == GNT_READ);
  assign gnt_rd_o = en_i && rd_req_i && (!wr_req_i || last_q == GNT_WRITE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)        last_q <= GNT_READ;
    else if (gnt_wr_o) last_q <= GNT_WRITE;
    else if (gnt_rd_o) last_q <= GNT_READ;
  end
endmodule

// File: rtl/flash_access_arbiter.sv
// Sequences log writes and readback reads onto a NOR flash interface with
// fixed cycle windows, since the interface gives no completion indication.
module flash_access_arbiter
  import flash_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF,
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int CMD_HOLD  = CMD_HOLD_DEF,
  parameter int LOG_BASE  = 0,
  parameter int LOG_DEPTH = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_drop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ptr_clear,
  output logic [1:0]        flash_cmd,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_wdata,
  input  logic [DATA_W-1:0] flash_rdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              full,
  output logic              busy
);
  localparam int NMAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int TW   = $clog2(NMAX + 2);
  localparam int CW   = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     count_q, count_d;
  logic              clr_q, clr_d;
  logic              idle, gnt_wr, gnt_rd;
  logic [TW-1:0]     target;

  assign idle   = (state_q == ST_IDLE);
  assign full   = (count_q == CW'(LOG_DEPTH));
  assign wr_ptr = ADDR_W'(LOG_BASE) + count_q[ADDR_W-1:0];
  assign target = op_wr_q ? TW'(WR_CYCLES) : TW'(RD_CYCLES);

  flash_rr_arbiter u_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .en_i     (idle),
    .wr_req_i (wr_req && !full),
    .rd_req_i (rd_req),
    .gnt_wr_o (gnt_wr),
    .gnt_rd_o (gnt_rd)
  );

  // cnt_q holds the number of cycles elapsed since issue, starting at 1 in
  // the first ISSUE cycle, so the DONE cycle lands at t0+N+1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    count_d = count_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ptr_clear) count_d = '0;
        if (gnt_wr) begin
          op_wr_d = 1'b1;
          addr_d  = wr_ptr;
          wdata_d = wr_data;
          cnt_d   = TW'(1);
          state_d = ST_ISSUE;
        end else if (gnt_rd) begin
          op_wr_d = 1'b0;
          addr_d  = rd_addr;
          cnt_d   = TW'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + TW'(1);
        if (ptr_clear) clr_d = 1'b1;
        if (cnt_q == TW'(CMD_HOLD)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (ptr_clear) clr_d = 1'b1;
        if (cnt_q == target) begin
          state_d = ST_DONE;
          if (!op_wr_q) rdata_d = flash_rdata;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (op_wr_q && !full) count_d = count_q + CW'(1);
        // A clear seen anywhere in the operation overrides the increment.
        if (clr_q || ptr_clear) count_d = '0;
        clr_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
      clr_q   <= clr_d;
    end
  end

  assign busy        = !idle;
  assign flash_cmd   = (state_q == ST_ISSUE) ? (op_wr_q ? CMD_WRITE : CMD_READ) : CMD_IDLE;
  assign flash_addr  = addr_q;
  assign flash_wdata = wdata_q;
  assign rd_data     = rdata_q;
  assign wr_ack      = (state_q == ST_DONE) && op_wr_q;
  assign rd_valid    = (state_q == ST_DONE) && !op_wr_q;
  assign wr_drop     = idle && wr_req && full;
endmodule

// File: doc/flash_access_arbiter.md
Name: flash_access_arbiter

Overview:
Shares the NOR flash interface between two requesters and sequences every access.
- Log writer: appends 16-bit words at an auto-incrementing pointer.
- Readback port: random-address 16-bit reads for telemetry.
The flash interface has no done/busy output, so this block owns access timing with fixed per-operation cycle windows. It drives the interface's command, address and write-data inputs and captures its read-data output.

Parameters:
ADDR_W, 22, flash word-address width
DATA_W, 16, flash data width
WR_CYCLES, 24, cycles from command issue to write completion (≥ CMD_HOLD+1)
RD_CYCLES, 16, cycles from command issue to read-data capture (≥ CMD_HOLD+1)
CMD_HOLD, 2, cycles flash_cmd is held non-zero per operation (≥1)
LOG_BASE, 0, first log address
LOG_DEPTH, 4096, number of log words before full

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous active-low reset
wr_req  in  1  log-write request; level, held until wr_ack
wr_data  in  DATA_W  word to append; sampled at grant
wr_ack  out  1  one-cycle pulse: write completed
wr_drop  out  1  one-cycle pulse: wr_req seen while full, request discarded
rd_req  in  1  read request; level, held until rd_valid
rd_addr  in  ADDR_W  read address; sampled at grant
rd_valid  out  1  one-cycle pulse: rd_data valid
rd_data  out  DATA_W  captured read word; holds until next read
ptr_clear  in  1  pulse: reset log pointer to LOG_BASE
flash_cmd  out  2  to interface: 0 idle, 1 read, 2 write
flash_addr  out  ADDR_W  to interface address
flash_wdata  out  DATA_W  to interface write data
flash_rdata  in  DATA_W  from interface read data
wr_ptr  out  ADDR_W  next log address
full  out  1  log holds LOG_DEPTH words
busy  out  1  operation in progress

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous, active-low.
- Reset values: every output 0 except wr_ptr=LOG_BASE. FSM=IDLE, last_grant=READ, count=0.
- FSM states and transitions:
  - IDLE: grant a request at the rising edge; latch op, address and data; → ISSUE.
  - ISSUE: flash_cmd=op for CMD_HOLD cycles; → WAIT.
  - WAIT: flash_cmd=0 until the cycle counter reaches WR_CYCLES or RD_CYCLES from issue; → DONE.
  - DONE: one cycle; pulse wr_ack or rd_valid; → IDLE.
- Latency: grant at edge t0. flash_cmd non-zero in cycles t0+1 .. t0+CMD_HOLD. Ack/valid asserted in cycle t0+N+1 (N = WR_CYCLES or RD_CYCLES). Minimum gap between operations is 1 IDLE cycle.
- flash_addr and flash_wdata are stable from ISSUE through DONE. They hold their last value in IDLE.
- Read capture: rd_data loads flash_rdata on the WAIT→DONE edge.
- Arbitration:
  - One requester pending: it wins.
  - Both pending: the requester not in last_grant wins (round-robin).
  - last_grant updates at grant. After reset, write wins the first tie.
- Write pointer:
  - wr_ptr = LOG_BASE + count. count is ADDR_W+1 bits wide and increments in DONE of a write.
  - full = (count == LOG_DEPTH). No wrap-around: pointer saturates.
- wr_req while full and FSM in IDLE: not granted. wr_drop pulses one cycle. Requester must drop wr_req.
  - A read pending in the same cycle is granted normally.
- ptr_clear:
  - In IDLE: count→0 next edge; full clears.
  - During an operation: latched and applied at DONE, after that write's increment (clear wins).
- Request dropped before ack: the operation completes anyway and the ack still pulses.
- Requests during ISSUE, WAIT or DONE are ignored until IDLE.
- busy = (FSM ≠ IDLE).
- Reset mid-operation: all outputs return to reset values immediately, including flash_cmd=0. The flash interface shares RESET and aborts too. Partially issued flash writes are not retried.
- Widths: address arithmetic is modulo 2^ADDR_W. LOG_BASE+LOG_DEPTH ≤ 2^ADDR_W by configuration.

Decomposition:
- Shared package flash_pkg: flash command encodings (CMD_IDLE=0, CMD_READ=1, CMD_WRITE=2), FSM state enum, default timing constants, ADDR_W/DATA_W defaults.
- One natural sub-module: flash_rr_arbiter (2-way round-robin, combinational grant plus last_grant register).
- FSM, timing counter and pointer stay in the top module.

Test Plan:
- wr_req=1, wr_data=16'hA5A5, default params → flash_cmd=2 for 2 cycles; flash_addr=0, flash_wdata=A5A5; wr_ack at t0+25; wr_ptr=1.
- rd_req=1, rd_addr=22'h000123, flash_rdata=16'hBEEF → flash_cmd=1, flash_addr=000123; rd_valid at t0+17 with rd_data=BEEF.
- wr_req and rd_req both held from reset → order write, read, write, read. Gap of exactly 1 IDLE cycle between ops.
- LOG_DEPTH=4, five writes → 4 wr_acks; full=1; 5th yields wr_drop pulse and no flash_cmd. ptr_clear → wr_ptr=0, full=0.
- ptr_clear pulsed during WAIT of the write to address 2 → ack still pulses; wr_ptr=0 after DONE.
- RESET low during WAIT of a write → flash_cmd=0, busy=0, no wr_ack. After release, a new request is serviced normally.
